ssd_scan_ctrl: RTL and testbench

- Time-multiplexed four-digit seven-segment scan controller for the Nexys3 display in the PmodGYRO demo.
- Accepts a 16-bit hex/BCD word through a valid/ready handshake and double-buffers it so updates land only on frame boundaries.
- Scans digits 0..3 with an anti-ghosting blank interval between digits.
- Drives the 2-bit digit index consumed by decimal_select, and merges the returned decimal-point level into the cathode outputs.

---
 rtl/ssd_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 11 +
 rtl/ssd_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: blank patterns,
// the active-low segment table and the scan FSM encoding.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n is the glyph for hex digit n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller with double-buffered data load.
// New words land in the display register only on frame boundaries, and each
// digit slot ends with a short all-anodes-off interval to suppress ghosting.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        dp_in,
    output logic [1:0]  control,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DRIVE_LEN = REFRESH_DIV - BLANK_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_LEN - 1);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx, idx_next;
    logic             slot_end, frame_end;

    logic [15:0]      pending, display;
    logic             pending_full;

    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic             lead_blank;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_end  = slot_end && (idx == 2'd3);
    assign control    = idx;
    assign data_ready = ~pending_full;
    assign nibble     = display[{idx, 2'b00} +: 4];

    seg7_decoder u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Suppress a digit when it and every more significant nibble are zero
    always_comb begin
        lead_blank = 1'b0;
        case (idx)
            2'd3:    lead_blank = (display[15:12] == 4'h0);
            2'd2:    lead_blank = (display[15:8]  == 8'h00);
            2'd1:    lead_blank = (display[15:4]  == 12'h000);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    assign lead_blank = 1'b0;
`endif

    // Scan state, slot counter and digit index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_DRIVE;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic and the drive/blank output pattern for the current slot
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        idx_next   = idx;
        an_next    = AN_OFF;
        seg_next   = SEG_BLANK;
        dp_next    = 1'b1;

        if (slot_end) begin
            cnt_next   = '0;
            idx_next   = idx + 2'd1;
            state_next = ST_DRIVE;
        end else if (state == ST_DRIVE && cnt == DRIVE_LAST) begin
            state_next = ST_BLANK;
        end

        if (state == ST_DRIVE) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = lead_blank ? SEG_BLANK : seg_dec;
            dp_next  = dp_in;
        end
    end

    // Double buffer: pending accepts a word, display takes it at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 16'h0000;
            display      <= 16'h0000;
            pending_full <= 1'b0;
        end else if (frame_end && pending_full) begin
            display      <= pending;
            pending_full <= 1'b0;
        end else if (data_valid && !pending_full) begin
            pending      <= data_in;
            pending_full <= 1'b1;
        end
    end

    // Registered pad outputs, one cycle behind control
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with a cycle-position reference model.
// Expected pad outputs are queued before each clock edge and popped after it.
module tb_ssd_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        dp_in;
    logic        dp_mode;
    logic [1:0]  control;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    // Stand-in for decimal_select: point lit only on digit 2 when enabled
    assign dp_in = (dp_mode && control == 2'd2) ? 1'b0 : 1'b1;

    ssd_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .dp_in      (dp_in),
        .control    (control),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    int          errors = 0;
    int          checks = 0;
    int          m_t;
    logic [15:0] m_pending;
    logic [15:0] m_display;
    logic        m_full;
    out_t        exp_q[$];

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, expv, m_t);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_full    = 1'b0;
        m_pending = 16'h0000;
        m_display = 16'h0000;
        exp_q.delete();
    endtask

    task automatic reset_checks();
        chk("rst_an",      an,         4'b1111);
        chk("rst_seg",     seg,        7'h7F);
        chk("rst_dp",      dp,         1'b1);
        chk("rst_control", control,    2'd0);
        chk("rst_ready",   data_ready, 1'b1);
    endtask

    // One clock: check combinational outputs, queue expected pad values,
    // advance, then compare and update the reference model.
    task automatic cycle();
        int   idx;
        int   pos;
        logic drive;
        logic lz;
        out_t e;
        out_t got;
        idx   = (m_t / RD) % 4;
        pos   = m_t % RD;
        drive = (pos < RD - BC);
        chk("control", control, idx);
        chk("ready", data_ready, !m_full);
        lz = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        lz = (idx > 0) && ((m_display >> (4 * idx)) == 16'h0000);
`endif
        if (drive) begin
            e.an  = ~(4'b0001 << idx);
            e.seg = lz ? 7'h7F : ref_seg(m_display[idx*4 +: 4]);
            e.dp  = (dp_mode && idx == 2) ? 1'b0 : 1'b1;
        end else begin
            e = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            reset_checks();
        end else begin
            got = '{an: an, seg: seg, dp: dp};
            e   = exp_q.pop_front();
            chk("an",  got.an,  e.an);
            chk("seg", got.seg, e.seg);
            chk("dp",  got.dp,  e.dp);
            if (pos == RD - 1 && idx == 3 && m_full) begin
                m_display = m_pending;
                m_full    = 1'b0;
            end else if (data_valid && !m_full) begin
                m_pending = data_in;
                m_full    = 1'b1;
            end
            m_t++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [15:0] v, input int hold);
        data_in    = v;
        data_valid = 1'b1;
        run(hold);
        data_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = 16'h0000;
        data_valid = 1'b0;
        dp_mode    = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        reset_checks();
        rst = 1'b0;

        // Idle scan of blank display
        run(45);
        // Mid-frame load; stays hidden until the frame boundary
        load(16'h12AF, 1);
        run(4);
        // Request while pending is full must be ignored
        load(16'hFFFF, 2);
        run(12);
        // New frame shows 12AF; decimal point on digit 2
        dp_mode = 1'b1;
        run(36);
        // Fill pending, then reset during digit 2 before it can land
        load(16'h3456, 1);
        run(13);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(40);
        // Leading-zero candidate value
        load(16'h0050, 1);
        run(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
